// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared definitions for the BCD 7-segment display stage.
//   - state_e   : scan FSM states (DIG0_ON=0, BLANK0=1, DIG1_ON=2, BLANK1=3)
//   - SEG_OFF   : all segments dark (active-low)
//   - SEG_DASH  : only segment g lit, shown for non-BCD codes
//   - SEG_TAB   : 16-entry active-low {g,f,e,d,c,b,a} table, index = digit code
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    DIG0_ON = 2'd0,
    BLANK0  = 2'd1,
    DIG1_ON = 2'd2,
    BLANK1  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Entry 0 is the rightmost element; codes 10..15 all map to a dash.
  localparam logic [15:0][6:0] SEG_TAB = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,  // 15..10
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,                           // 9..5
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40                            // 4..0
  };

endpackage

// File: rtl/bcd_seg_mux_if.sv
// bcd_seg_mux_if: digit inputs and display outputs of the scan stage.
//   bcd0/bcd1  : units/tens BCD digits from the counter
//   seg        : active-low segments {g,f,e,d,c,b,a}
//   an         : active-low anodes {tens,units}
//   frame_done : 1-cycle pulse when a new digit snapshot is taken
//   modport master: counter/test side; modport slave: display stage.
interface bcd_seg_mux_if;
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  modport master (output bcd0, bcd1, input seg, an, frame_done);
  modport slave  (input bcd0, bcd1, output seg, an, frame_done);
endinterface

// File: rtl/bcd_seg_mux_dec.sv
// bcd_to_seg7: combinational 4-bit code -> 7-bit active-low segment decoder.
//   bcd_i : digit code (10..15 decode to a dash)
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TAB[bcd_i];
endmodule

// File: rtl/bcd_seg_mux.sv
// bcd_seg_mux: time-multiplexed driver for a 2-digit common-anode display.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   disp : bcd_seg_mux_if.slave (bcd0/bcd1 in; seg/an/frame_done out, registered)
// Scan order DIG0_ON -> BLANK0 -> DIG1_ON -> BLANK1, both digits snapshotted
// on the edge entering DIG0_ON so a frame never shows a torn count.
// Optional macro LEADING_ZERO_BLANK_EN: keep the tens digit dark when it is 0.
module bcd_seg_mux
  import bcd_disp_pkg::*;
#(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 1000,
  localparam int CNT_W =
    $clog2(((ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES) + 1)
) (
  input  logic         clk,
  input  logic         rst,
  bcd_seg_mux_if.slave disp
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dwell_last;
  logic [3:0]       snap0_q, snap0_d, snap1_q, snap1_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d, dec_seg;
  logic             fd_q, fd_d;
  logic [3:0]       digit;

  assign dwell_last = (state_q == DIG0_ON || state_q == DIG1_ON)
                    ? CNT_W'(ON_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1);

  // Outputs are derived from next-state values so they change on the same
  // edge as the state, with no extra register stage of latency.
  assign digit = (state_d == DIG1_ON) ? snap1_d : snap0_d;

  bcd_to_seg7 u_dec (.bcd_i(digit), .seg_o(dec_seg));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    fd_d    = 1'b0;
    if (cnt_q == dwell_last) begin
      cnt_d = '0;
      case (state_q)
        DIG0_ON: state_d = BLANK0;
        BLANK0:  state_d = DIG1_ON;
        DIG1_ON: state_d = BLANK1;
        default: begin
          state_d = DIG0_ON;
          snap0_d = disp.bcd0;
          snap1_d = disp.bcd1;
          fd_d    = 1'b1;
        end
      endcase
    end

    an_d  = 2'b11;
    seg_d = SEG_OFF;
    case (state_d)
      DIG0_ON: begin
        an_d  = 2'b10;
        seg_d = dec_seg;
      end
      DIG1_ON: begin
        an_d  = 2'b01;
        seg_d = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (snap1_d == 4'd0) begin
          an_d  = 2'b11;
          seg_d = SEG_OFF;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK1;
      cnt_q   <= '0;
      snap0_q <= '0;
      snap1_q <= '0;
      an_q    <= 2'b11;
      seg_q   <= SEG_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign disp.seg        = seg_q;
  assign disp.an         = an_q;
  assign disp.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_mux.sv
// tb_bcd_seg_mux: table-driven check of bcd_seg_mux with ON_CYCLES=4,
// BLANK_CYCLES=2 (12-cycle frame), plus hand-written mid-frame input change
// and mid-frame reset sequences.
module tb_bcd_seg_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bcd_seg_mux_if disp ();

  bcd_seg_mux #(.ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp)
  );

  typedef struct {
    logic [3:0] b1;
    logic [3:0] b0;
    logic [6:0] s0;   // units segments
    logic [6:0] s1;   // tens segments
    logic [1:0] an1;  // anodes during DIG1_ON
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got an/seg/fd=%h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until frame_done; the number of cycles taken must equal exp_wait.
  task automatic wait_frame(input int exp_wait);
    int n = 0;
    bit seen = 0;
    while (n < 40 && !seen) begin
      tick();
      n++;
      if (disp.frame_done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != exp_wait) begin
      failures++;
      $display("FAIL frame_wait: got %0d cycles (seen=%0d) required %0d", n, seen, exp_wait);
    end
  endtask

  // Called on the first DIG0_ON cycle. Checks up to 12 cycles of a frame.
  // chg_at: cycle index after which inputs change to nb1/nb0.
  // rst_at: cycle index after which rst is raised and the task returns.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [1:0] an1, input int chg_at,
                             input logic [3:0] nb1, input logic [3:0] nb0,
                             input int rst_at);
    logic [9:0] exp;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      if (i < 4)       exp = {2'b10, s0, (i == 0) ? 1'b1 : 1'b0};
      else if (i < 6)  exp = {2'b11, 7'h7F, 1'b0};
      else if (i < 10) exp = {an1, s1, 1'b0};
      else             exp = {2'b11, 7'h7F, 1'b0};
      chk($sformatf("frame_c%0d", i), {disp.an, disp.seg, disp.frame_done}, exp);
      chk("an_not_00", {9'd0, disp.an == 2'b00}, 10'd0);
      if (i == chg_at) begin
        disp.bcd1 = nb1;
        disp.bcd0 = nb0;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    vecs[0] = '{4'd4, 4'd7, 7'h78, 7'h19, 2'b01};
    vecs[1] = '{4'd9, 4'd8, 7'h00, 7'h10, 2'b01};
    vecs[2] = '{4'd1, 4'd6, 7'h02, 7'h79, 2'b01};
    vecs[3] = '{4'hF, 4'hC, 7'h3F, 7'h3F, 2'b01};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[4] = '{4'd0, 4'd5, 7'h12, 7'h7F, 2'b11};
`else
    vecs[4] = '{4'd0, 4'd5, 7'h12, 7'h40, 2'b01};
`endif
    vecs[5] = '{4'd8, 4'd0, 7'h40, 7'h00, 2'b01};

    // Reset held 3 cycles, inputs already at the first vector.
    disp.bcd1 = vecs[0].b1;
    disp.bcd0 = vecs[0].b0;
    repeat (3) tick();
    chk("reset_state", {disp.an, disp.seg, disp.frame_done}, {2'b11, 7'h7F, 1'b0});
    rst = 1'b0;
    tick();
    chk("post_reset_blank", {disp.an, disp.seg, disp.frame_done}, {2'b11, 7'h7F, 1'b0});
    wait_frame(1);
    check_frame(vecs[0].s0, vecs[0].s1, vecs[0].an1, -1, 4'd0, 4'd0, -1);
    // Held inputs: next frame starts exactly 12 cycles after the last.
    wait_frame(1);
    check_frame(vecs[0].s0, vecs[0].s1, vecs[0].an1, -1, 4'd0, 4'd0, -1);

    for (int v = 1; v < 6; v++) begin
      disp.bcd1 = vecs[v].b1;
      disp.bcd0 = vecs[v].b0;
      wait_frame(1);
      check_frame(vecs[v].s0, vecs[v].s1, vecs[v].an1, -1, 4'd0, 4'd0, -1);
    end

    // Inputs change on the 2nd DIG0_ON cycle; the frame keeps its snapshot.
    disp.bcd1 = 4'd2;
    disp.bcd0 = 4'd3;
    wait_frame(1);
    check_frame(7'h30, 7'h24, 2'b01, 1, 4'd8, 4'd5, -1);
    wait_frame(1);
    check_frame(7'h12, 7'h00, 2'b01, -1, 4'd0, 4'd0, -1);

    // Reset raised during the 3rd DIG1_ON cycle.
    disp.bcd1 = 4'd4;
    disp.bcd0 = 4'd7;
    wait_frame(1);
    check_frame(7'h78, 7'h19, 2'b01, -1, 4'd0, 4'd0, 8);
    tick();
    chk("midframe_reset", {disp.an, disp.seg, disp.frame_done}, {2'b11, 7'h7F, 1'b0});
    rst = 1'b0;
    tick();
    chk("restart_blank", {disp.an, disp.seg, disp.frame_done}, {2'b11, 7'h7F, 1'b0});
    wait_frame(1);
    check_frame(7'h78, 7'h19, 2'b01, -1, 4'd0, 4'd0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
